// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg
//   Shared definitions for the data-memory / I/O unit: I/O register
//   addresses, the TSTAT overflow bit position, the decode-select encoding
//   and a helper for word-granular address matching.
package dmem_io_pkg;

  localparam logic [15:0] ADDR_LED    = 16'hFF00;
  localparam logic [15:0] ADDR_SW     = 16'hFF02;
  localparam logic [15:0] ADDR_TCOUNT = 16'hFF04;
  localparam logic [15:0] ADDR_TSTAT  = 16'hFF06;

  localparam int TSTAT_OVF_BIT = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TSTAT
  } sel_e;

  // Byte addresses are compared as word addresses, so the odd byte of a
  // register decodes to the same register.
  function automatic logic word_match(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:1] == base[15:1];
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// dmem_timer
//   Free-running prescaled 16-bit timer with sticky overflow flag.
//   Ports:
//     clock, reset      system clock, asynchronous active-high reset
//     load, load_value  load TCOUNT (also restarts the prescaler)
//     clear             clear the overflow flag (write-1-clear strobe)
//     count             current TCOUNT value
//     ovf               sticky overflow flag
module dmem_timer #(
  parameter int PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        clear,
  output logic [15:0] count,
  output logic        ovf
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] prescale_cnt;
  logic       tick;
  logic       ovf_set;

  assign tick    = (prescale_cnt == PRE_LAST);
  // A load on the wrap cycle replaces the increment, so it cannot overflow.
  assign ovf_set = tick && !load && (count == 16'hFFFF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_cnt <= '0;
      count        <= '0;
      ovf          <= 1'b0;
    end else begin
      if (load) begin
        count        <= load_value;
        prescale_cnt <= '0;
      end else begin
        prescale_cnt <= tick ? 8'd0 : 8'(prescale_cnt + 8'd1);
        if (tick) begin
          count <= count + 16'd1;
        end
      end
      // Set has priority so an overflow is never lost to a racing clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clear) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_io_unit.sv
// dmem_io_unit
//   Data RAM plus memory-mapped I/O (LEDs, switches, timer) for the CPU
//   MEM stage. Loads are combinational; stores commit on the rising edge.
//   Ports:
//     clock, reset   system clock, asynchronous active-high reset
//     dmemaddr       byte address (bit 0 ignored)
//     dmemwdata      store data
//     dmemwrite      store enable
//     dmemread       load enable; dmemrdata is 0 when low
//     dmemrdata      load data
//     sw_in          asynchronous switch inputs
//     led_out        LED register
module dmem_io_unit
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS = 128,
  parameter int PRESCALE  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out
);

  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [15:0] RAM_LIMIT = 16'(RAM_WORDS);

  logic [15:0]       ram [RAM_WORDS];
  logic [14:0]       word_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic              addr_lsb_unused;
  sel_e              sel;

  logic [7:0]  sw_meta_p0;
  logic [7:0]  sw_sync_p1;
  logic [15:0] tcount;
  logic        ovf;
  logic        timer_load;
  logic        timer_clear;

  assign word_idx        = dmemaddr[15:1];
  assign ram_idx         = word_idx[RAM_AW-1:0];
  assign addr_lsb_unused = dmemaddr[0];

  always_comb begin
    sel = SEL_NONE;
    if ({1'b0, word_idx} < RAM_LIMIT) begin
      sel = SEL_RAM;
    end else if (word_match(dmemaddr, ADDR_LED)) begin
      sel = SEL_LED;
    end else if (word_match(dmemaddr, ADDR_SW)) begin
      sel = SEL_SW;
    end else if (word_match(dmemaddr, ADDR_TCOUNT)) begin
      sel = SEL_TCOUNT;
    end else if (word_match(dmemaddr, ADDR_TSTAT)) begin
      sel = SEL_TSTAT;
    end
  end

  // RAM contents survive reset; stores are only blocked while it is held.
  always_ff @(posedge clock) begin
    if (dmemwrite && !reset && (sel == SEL_RAM)) begin
      ram[ram_idx] <= dmemwdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else if (dmemwrite && (sel == SEL_LED)) begin
      led_out <= dmemwdata[7:0];
    end
  end

  // Stage p0: capture the asynchronous switches (may go metastable).
  // Stage p1: settled value, the only one software can observe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_p0 <= '0;
      sw_sync_p1 <= '0;
    end else begin
      sw_meta_p0 <= sw_in;
      sw_sync_p1 <= sw_meta_p0;
    end
  end

  assign timer_load  = dmemwrite && (sel == SEL_TCOUNT);
  assign timer_clear = dmemwrite && (sel == SEL_TSTAT) && dmemwdata[TSTAT_OVF_BIT];

  dmem_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (dmemwdata),
    .clear      (timer_clear),
    .count      (tcount),
    .ovf        (ovf)
  );

  always_comb begin
    dmemrdata = '0;
    if (dmemread) begin
      case (sel)
        SEL_RAM:    dmemrdata = ram[ram_idx];
        SEL_LED:    dmemrdata = {8'h00, led_out};
        SEL_SW:     dmemrdata = {8'h00, sw_sync_p1};
        SEL_TCOUNT: dmemrdata = tcount;
        SEL_TSTAT:  dmemrdata[TSTAT_OVF_BIT] = ovf;
        default:    dmemrdata = '0;
      endcase
    end
  end

endmodule
